// File: rtl/hsv_core_mem_resp_tracker_if.sv
// Request, AXI R/B response and commit channels of the memory response tracker.
// master = producer/consumer around the tracker; slave = the tracker itself.
interface hsv_core_mem_resp_tracker_if #(
  parameter int unsigned TAG_W = 5
) ();
  logic             req_valid;
  logic             req_ready;
  logic             req_is_read;
  logic             req_is_memory;
  logic [1:0]       req_size;
  logic             req_sign_extend;
  logic             req_misaligned;
  logic [31:0]      req_addr;
  logic [TAG_W-1:0] req_tag;

  logic             dmem_r_valid;
  logic [31:0]      dmem_r_data;
  logic [1:0]       dmem_r_resp;
  logic             dmem_r_ready;

  logic             dmem_b_valid;
  logic [1:0]       dmem_b_resp;
  logic             dmem_b_ready;

  logic             out_valid;
  logic             out_ready;
  logic [TAG_W-1:0] out_tag;
  logic [31:0]      out_result;
  logic             out_writeback;
  logic             out_exception;
  logic [3:0]       out_cause;
  logic [31:0]      out_exc_value;

  modport master (
    output req_valid, req_is_read, req_is_memory, req_size, req_sign_extend, req_misaligned,
    output req_addr, req_tag,
    input  req_ready,
    output dmem_r_valid, dmem_r_data, dmem_r_resp,
    input  dmem_r_ready,
    output dmem_b_valid, dmem_b_resp,
    input  dmem_b_ready,
    input  out_valid, out_tag, out_result, out_writeback, out_exception, out_cause,
    input  out_exc_value,
    output out_ready
  );

  modport slave (
    input  req_valid, req_is_read, req_is_memory, req_size, req_sign_extend, req_misaligned,
    input  req_addr, req_tag,
    output req_ready,
    input  dmem_r_valid, dmem_r_data, dmem_r_resp,
    output dmem_r_ready,
    input  dmem_b_valid, dmem_b_resp,
    output dmem_b_ready,
    output out_valid, out_tag, out_result, out_writeback, out_exception, out_cause,
    output out_exc_value,
    input  out_ready
  );
endinterface

// File: rtl/hsv_core_mem_resp_tracker.sv
// In-order tracker pairing AXI R/B beats with queued op metadata; one commit record per op.
// Optional HSV_MEM_RESP_WERR_EN: pulse async_werr_o on an erroring posted-write B beat.
module hsv_core_mem_resp_tracker #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned TAG_W           = 5
) (
  input  logic                              clk_core,
  input  logic                              rst_core_n,
  input  logic                              flush_i,
  hsv_core_mem_resp_tracker_if.slave        bus,
  output logic                              idle_o,
  output logic                              async_werr_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned OccW = $clog2(DEPTH + 1);
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SumW = CntW + 2;

  typedef struct packed {
    logic             is_read;
    logic             is_memory;
    logic [1:0]       size;
    logic             sign_ext;
    logic             misaligned;
    logic [31:0]      addr;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0]  occ_q, occ_d;
  logic [CntW-1:0]  posted_w_q, posted_w_d, drain_r_q, drain_r_d, drain_w_q, drain_w_d;

  logic             out_valid_q, out_valid_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic [31:0]      out_result_q, out_result_d;
  logic             out_wb_q, out_wb_d;
  logic             out_exc_q, out_exc_d;
  logic [3:0]       out_cause_q, out_cause_d;
  logic [31:0]      out_exc_value_q, out_exc_value_d;

  entry_t           head, entry_in;
  logic             not_empty, full, push, pop, out_free, head_done;
  logic             head_read, head_io_write, head_mem_write;
  logic             r_hs, b_hs, r_drain, b_drain, b_posted, r_err, b_err;
  logic [SumW-1:0]  outstanding;
  logic [OccW-1:0]  q_reads, q_writes;
  logic [31:0]      shifted, load_data;

  assign entry_in = '{is_read: bus.req_is_read, is_memory: bus.req_is_memory,
                      size: bus.req_size, sign_ext: bus.req_sign_extend,
                      misaligned: bus.req_misaligned, addr: bus.req_addr, tag: bus.req_tag};

  assign head      = mem_q[rd_ptr_q];
  assign not_empty = (occ_q != '0);
  assign full      = (occ_q == OccW'(DEPTH));
  assign outstanding = SumW'(occ_q) + SumW'(posted_w_q) + SumW'(drain_r_q) + SumW'(drain_w_q);

  assign bus.req_ready = !full && (outstanding < SumW'(MAX_OUTSTANDING)) && !flush_i;
  assign push          = bus.req_valid && bus.req_ready;

  assign head_read      = not_empty && head.is_read && !head.misaligned;
  assign head_io_write  = not_empty && !head.is_read && !head.is_memory && !head.misaligned;
  assign head_mem_write = not_empty && !head.is_read && head.is_memory && !head.misaligned;
  assign out_free       = (!out_valid_q || bus.out_ready) && !flush_i;
  assign r_err          = (bus.dmem_r_resp >= 2'd2);
  assign b_err          = (bus.dmem_b_resp >= 2'd2);

  always_comb begin
    head_done = 1'b0;
    if (head.misaligned)     head_done = 1'b1;
    else if (head.is_read)   head_done = (drain_r_q == '0) && bus.dmem_r_valid;
    else if (head.is_memory) head_done = 1'b1;
    else head_done = (posted_w_q == '0) && (drain_w_q == '0) && bus.dmem_b_valid;
  end

  assign pop = not_empty && head_done && out_free;

  // Drain counters own the channel; otherwise only a head that can pop may take the beat.
  assign bus.dmem_r_ready = (drain_r_q != '0) || (head_read && out_free);
  assign bus.dmem_b_ready = (drain_w_q != '0) || (posted_w_q != '0) || (head_io_write && out_free);

  assign r_hs     = bus.dmem_r_valid && bus.dmem_r_ready;
  assign b_hs     = bus.dmem_b_valid && bus.dmem_b_ready;
  assign r_drain  = r_hs && (drain_r_q != '0);
  assign b_drain  = b_hs && (drain_w_q != '0);
  assign b_posted = b_hs && (drain_w_q == '0) && (posted_w_q != '0);

  // Issued ops still queued; queued memory writes were issued too, so their B beats drain.
  always_comb begin
    q_reads  = '0;
    q_writes = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (OccW'(k) < occ_q && !mem_q[rd_ptr_q + PtrW'(k)].misaligned) begin
        if (mem_q[rd_ptr_q + PtrW'(k)].is_read) q_reads  = q_reads + OccW'(1);
        else                                    q_writes = q_writes + OccW'(1);
      end
    end
  end

  always_comb begin
    shifted = bus.dmem_r_data >> {head.addr[1:0], 3'b000};
    case (head.size)
      2'd0:    load_data = {{24{head.sign_ext & shifted[7]}}, shifted[7:0]};
      2'd1:    load_data = {{16{head.sign_ext & shifted[15]}}, shifted[15:0]};
      2'd2:    load_data = shifted;
      default: load_data = 'x;
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q + PtrW'(push);
    rd_ptr_d   = rd_ptr_q + PtrW'(pop);
    occ_d      = occ_q + OccW'(push) - OccW'(pop);
    posted_w_d = posted_w_q - CntW'(b_posted) + CntW'(pop && head_mem_write);
    drain_r_d  = drain_r_q - CntW'(r_drain);
    drain_w_d  = drain_w_q - CntW'(b_drain);
    if (flush_i) begin
      wr_ptr_d  = rd_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      occ_d     = '0;
      drain_r_d = drain_r_d + CntW'(q_reads);
      drain_w_d = drain_w_d + CntW'(q_writes);
    end
  end

  always_comb begin
    out_valid_d     = out_valid_q;
    out_tag_d       = out_tag_q;
    out_result_d    = out_result_q;
    out_wb_d        = out_wb_q;
    out_exc_d       = out_exc_q;
    out_cause_d     = out_cause_q;
    out_exc_value_d = out_exc_value_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (pop) begin
      out_valid_d     = 1'b1;
      out_tag_d       = head.tag;
      out_exc_value_d = head.addr;
      out_exc_d       = 1'b0;
      out_cause_d     = 4'd0;
      if (head.misaligned) begin
        out_exc_d   = 1'b1;
        out_cause_d = head.is_read ? 4'd4 : 4'd6;
      end else if (head.is_read && r_err) begin
        out_exc_d   = 1'b1;
        out_cause_d = 4'd5;
      end else if (head_io_write && b_err) begin
        out_exc_d   = 1'b1;
        out_cause_d = 4'd7;
      end
      out_wb_d     = head.is_read && !out_exc_d;
      out_result_d = out_wb_d ? load_data : 32'd0;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_core) begin
    if (push) mem_q[wr_ptr_q] <= entry_in;
  end

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      occ_q           <= '0;
      posted_w_q      <= '0;
      drain_r_q       <= '0;
      drain_w_q       <= '0;
      out_valid_q     <= 1'b0;
      out_tag_q       <= '0;
      out_result_q    <= '0;
      out_wb_q        <= 1'b0;
      out_exc_q       <= 1'b0;
      out_cause_q     <= '0;
      out_exc_value_q <= '0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      occ_q           <= occ_d;
      posted_w_q      <= posted_w_d;
      drain_r_q       <= drain_r_d;
      drain_w_q       <= drain_w_d;
      out_valid_q     <= out_valid_d;
      out_tag_q       <= out_tag_d;
      out_result_q    <= out_result_d;
      out_wb_q        <= out_wb_d;
      out_exc_q       <= out_exc_d;
      out_cause_q     <= out_cause_d;
      out_exc_value_q <= out_exc_value_d;
    end
  end

`ifdef HSV_MEM_RESP_WERR_EN
  logic werr_q;
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) werr_q <= 1'b0;
    else             werr_q <= b_posted && b_err;
  end
  assign async_werr_o = werr_q;
`else
  assign async_werr_o = 1'b0;
`endif

  assign bus.out_valid     = out_valid_q;
  assign bus.out_tag       = out_tag_q;
  assign bus.out_result    = out_result_q;
  assign bus.out_writeback = out_wb_q;
  assign bus.out_exception = out_exc_q;
  assign bus.out_cause     = out_cause_q;
  assign bus.out_exc_value = out_exc_value_q;
  assign idle_o = !not_empty && (posted_w_q == '0) && (drain_r_q == '0) && (drain_w_q == '0);

  a_outstanding_cap: assert property (@(posedge clk_core) disable iff (!rst_core_n)
    outstanding <= SumW'(MAX_OUTSTANDING));
  a_pop_nonempty: assert property (@(posedge clk_core) disable iff (!rst_core_n)
    pop |-> not_empty);
  a_r_matched: assert property (@(posedge clk_core) disable iff (!rst_core_n)
    bus.dmem_r_valid |-> (drain_r_q != '0) || (q_reads != '0));
  a_b_matched: assert property (@(posedge clk_core) disable iff (!rst_core_n)
    bus.dmem_b_valid |-> (drain_w_q != '0) || (posted_w_q != '0) || (q_writes != '0));
  a_size_legal: assert property (@(posedge clk_core) disable iff (!rst_core_n)
    (pop && head_read) |-> (head.size != 2'd3));

endmodule

// File: tb/tb_hsv_core_mem_resp_tracker.sv
// Scoreboard bench for hsv_core_mem_resp_tracker: expected commit records are queued with
// stimulus and checked by a monitor as records leave the commit port.
module tb_hsv_core_mem_resp_tracker;

  typedef struct packed {
    logic [4:0]  tag;
    logic [31:0] result;
    logic        wb;
    logic        exc;
    logic [3:0]  cause;
    logic [31:0] excval;
  } rec_t;

`ifdef HSV_MEM_RESP_WERR_EN
  localparam logic WerrExp = 1'b1;
`else
  localparam logic WerrExp = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic idle, async_werr;
  int   total = 0;
  int   bad = 0;
  rec_t sb[$];

  always #5 clk = ~clk;

  hsv_core_mem_resp_tracker_if #(.TAG_W(5)) bus ();

  hsv_core_mem_resp_tracker #(.DEPTH(4), .MAX_OUTSTANDING(8), .TAG_W(5)) dut (
    .clk_core     (clk),
    .rst_core_n   (rst_n),
    .flush_i      (flush),
    .bus          (bus),
    .idle_o       (idle),
    .async_werr_o (async_werr)
  );

  function automatic rec_t mk(input logic [4:0] tag, input logic [31:0] res, input logic wb,
                              input logic exc, input logic [3:0] cause, input logic [31:0] ev);
    rec_t r;
    r.tag = tag; r.result = res; r.wb = wb; r.exc = exc; r.cause = cause; r.excval = ev;
    return r;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] d, input logic [1:0] off,
                                           input logic [1:0] sz, input logic sx);
    logic [31:0] t;
    t = d >> (8 * off);
    case (sz)
      2'd0:    return sx ? 32'($signed(t[7:0]))  : {24'd0, t[7:0]};
      2'd1:    return sx ? 32'($signed(t[15:0])) : {16'd0, t[15:0]};
      default: return t;
    endcase
  endfunction

  // Commit monitor: every accepted record must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      rec_t act, exp;
      act = mk(bus.out_tag, bus.out_result, bus.out_writeback, bus.out_exception,
               bus.out_cause, bus.out_exc_value);
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL commit_unexpected got=%h want=none", act);
      end else begin
        exp = sb.pop_front();
        if (act !== exp) begin
          bad++;
          $display("FAIL commit tag=%0d got=%h want=%h", exp.tag, act, exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic rd, input logic memory, input logic [1:0] sz,
                          input logic sx, input logic mis, input logic [31:0] addr,
                          input logic [4:0] tag);
    int n = 0;
    bus.req_valid = 1'b1; bus.req_is_read = rd; bus.req_is_memory = memory;
    bus.req_size = sz; bus.req_sign_extend = sx; bus.req_misaligned = mis;
    bus.req_addr = addr; bus.req_tag = tag;
    #1;
    while (!bus.req_ready && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n == 20) begin
      total++; bad++;
      $display("FAIL push_timeout tag=%0d req_ready=%b want=1", tag, bus.req_ready);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 40) begin
      step();
      n++;
    end
    if (n == 40) begin
      total++; bad++;
      $display("FAIL %s_drain pending=%0d want=0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if ({bus.out_valid, idle, async_werr} !== 3'b010) begin bad++;
      $display("FAIL rst_hold valid/idle/werr=%b want=010", {bus.out_valid, idle, async_werr}); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b1) begin bad++;
      $display("FAIL rst_req_ready got=%b want=1", bus.req_ready); end
    total++; if ({bus.dmem_r_ready, bus.dmem_b_ready} !== 2'b00) begin bad++;
      $display("FAIL rst_ch_ready got=%b want=00", {bus.dmem_r_ready, bus.dmem_b_ready}); end
    total++; if ({bus.out_tag, bus.out_result, bus.out_cause, bus.out_exc_value} !== '0) begin
      bad++; $display("FAIL rst_out_fields got=%h want=0", bus.out_result); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL rst_idle got=%b want=1", idle); end
    step();
  endtask

  task automatic test_signed_byte();
    bus.out_ready = 1'b1;
    push_req(1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 32'h1003, 5'd1);
    bus.dmem_r_valid = 1'b1; bus.dmem_r_data = 32'h80AB_CDEF; bus.dmem_r_resp = 2'd0;
    sb.push_back(mk(5'd1, 32'hFFFF_FF80, 1'b1, 1'b0, 4'd0, 32'h1003));
    @(negedge clk);
    total++; if ({bus.dmem_r_ready, bus.out_valid} !== 2'b10) begin bad++;
      $display("FAIL sb_rready_novalid got=%b want=10", {bus.dmem_r_ready, bus.out_valid}); end
    step();
    bus.dmem_r_valid = 1'b0;
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b1) begin bad++;
      $display("FAIL sb_latency out_valid=%b want=1", bus.out_valid); end
    wait_drain("sb");
  endtask

  task automatic test_posted_and_io_write();
    sb.push_back(mk(5'd2, 32'd0, 1'b0, 1'b0, 4'd0, 32'h100));
    push_req(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 32'h100, 5'd2);
    push_req(1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 32'h200, 5'd3);
    repeat (3) step();
    @(negedge clk);
    total++; if ({bus.dmem_b_ready, bus.out_valid} !== 2'b10) begin bad++;
      $display("FAIL pw_io_blocked b_ready/valid=%b want=10", {bus.dmem_b_ready, bus.out_valid}); end
    @(posedge clk); #1;
    bus.dmem_b_valid = 1'b1; bus.dmem_b_resp = 2'd0;
    step();
    bus.dmem_b_valid = 1'b0;
    @(negedge clk);
    total++; if ({bus.dmem_b_ready, bus.out_valid} !== 2'b10) begin bad++;
      $display("FAIL pw_first_b b_ready/valid=%b want=10", {bus.dmem_b_ready, bus.out_valid}); end
    @(posedge clk); #1;
    sb.push_back(mk(5'd3, 32'd0, 1'b0, 1'b0, 4'd0, 32'h200));
    bus.dmem_b_valid = 1'b1;
    step();
    bus.dmem_b_valid = 1'b0;
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b1) begin bad++;
      $display("FAIL pw_io_commit out_valid=%b want=1", bus.out_valid); end
    wait_drain("pw");
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL pw_idle got=%b want=1", idle); end
  endtask

  task automatic test_flush_drain();
    for (int i = 0; i < 3; i++) push_req(1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 32'h40 + 4 * i, 5'(4 + i));
    flush = 1'b1;
    #1;
    total++; if (bus.req_ready !== 1'b0) begin bad++;
      $display("FAIL fl_req_ready got=%b want=0", bus.req_ready); end
    step();
    flush = 1'b0;
    @(negedge clk);
    total++; if ({idle, bus.out_valid} !== 2'b00) begin bad++;
      $display("FAIL fl_state idle/valid=%b want=00", {idle, bus.out_valid}); end
    @(posedge clk); #1;
    push_req(1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 32'h50, 5'd7);
    for (int k = 1; k <= 4; k++) begin
      bus.dmem_r_valid = 1'b1; bus.dmem_r_data = 32'(k); bus.dmem_r_resp = 2'd0;
      if (k == 4) sb.push_back(mk(5'd7, 32'd4, 1'b1, 1'b0, 4'd0, 32'h50));
      #1;
      total++; if (bus.dmem_r_ready !== 1'b1) begin bad++;
        $display("FAIL fl_r_ready beat=%0d got=%b want=1", k, bus.dmem_r_ready); end
      step();
    end
    bus.dmem_r_valid = 1'b0;
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b1) begin bad++;
      $display("FAIL fl_commit out_valid=%b want=1", bus.out_valid); end
    wait_drain("fl");
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL fl_idle got=%b want=1", idle); end
  endtask

  task automatic test_misaligned_store();
    sb.push_back(mk(5'd8, 32'd0, 1'b0, 1'b1, 4'd6, 32'h2001));
    push_req(1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 32'h2001, 5'd8);
    @(negedge clk);
    total++; if (bus.dmem_b_ready !== 1'b0) begin bad++;
      $display("FAIL ms_b_ready_head got=%b want=0", bus.dmem_b_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if ({bus.out_valid, bus.dmem_b_ready} !== 2'b10) begin bad++;
      $display("FAIL ms_commit valid/b_ready=%b want=10", {bus.out_valid, bus.dmem_b_ready}); end
    wait_drain("ms");
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL ms_idle got=%b want=1", idle); end
  endtask

  task automatic test_err_backpressure();
    logic [31:0] addr [4] = '{32'h3102, 32'h3201, 32'h3300, 32'h3400};
    logic [31:0] data [4] = '{32'hF00D_1234, 32'h0000_FF00, 32'h89AB_CDEF, 32'h1234_8765};
    logic [1:0]  sz   [4] = '{2'd1, 2'd0, 2'd2, 2'd1};
    logic        sx   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bus.out_ready = 1'b0;
    push_req(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 32'h3000, 5'd9);
    bus.dmem_r_valid = 1'b1; bus.dmem_r_data = 32'hDEAD_BEEF; bus.dmem_r_resp = 2'd3;
    sb.push_back(mk(5'd9, 32'd0, 1'b0, 1'b1, 4'd5, 32'h3000));
    step();
    bus.dmem_r_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_req(1'b1, 1'b1, sz[i], sx[i], 1'b0, addr[i], 5'(10 + i));
      @(negedge clk);
      total++;
      if ({bus.out_valid, bus.out_tag, bus.out_cause, bus.out_exception} !== {1'b1, 5'd9, 4'd5, 1'b1})
      begin bad++; $display("FAIL eb_hold cyc=%0d tag=%0d cause=%0d want tag=9 cause=5", i,
                            bus.out_tag, bus.out_cause); end
      @(posedge clk); #1;
    end
    total++; if (bus.req_ready !== 1'b0) begin bad++;
      $display("FAIL eb_full_req_ready got=%b want=0", bus.req_ready); end
    bus.out_ready = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      bus.dmem_r_valid = 1'b1; bus.dmem_r_data = data[i]; bus.dmem_r_resp = 2'd0;
      sb.push_back(mk(5'(10 + i), exp_load(data[i], addr[i][1:0], sz[i], sx[i]), 1'b1, 1'b0,
                      4'd0, addr[i]));
      step();
    end
    bus.dmem_r_valid = 1'b0;
    wait_drain("eb");
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL eb_idle got=%b want=1", idle); end
  endtask

  task automatic test_werr();
    sb.push_back(mk(5'd14, 32'd0, 1'b0, 1'b0, 4'd0, 32'h400));
    push_req(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 32'h400, 5'd14);
    step();
    bus.dmem_b_valid = 1'b1; bus.dmem_b_resp = 2'd2;
    @(negedge clk);
    total++; if (async_werr !== 1'b0) begin bad++;
      $display("FAIL we_before got=%b want=0", async_werr); end
    @(posedge clk); #1;
    bus.dmem_b_valid = 1'b0; bus.dmem_b_resp = 2'd0;
    @(negedge clk);
    total++; if (async_werr !== WerrExp) begin bad++;
      $display("FAIL we_pulse got=%b want=%b", async_werr, WerrExp); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (async_werr !== 1'b0) begin bad++;
      $display("FAIL we_after got=%b want=0", async_werr); end
    wait_drain("we");
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL we_idle got=%b want=1", idle); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      sb.push_back(mk(5'(15 + i), 32'd0, 1'b0, 1'b0, 4'd0, 32'h500 + 4 * i));
      push_req(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 32'h500 + 4 * i, 5'(15 + i));
    end
    push_req(1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 32'h600, 5'd21);
    push_req(1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 32'h604, 5'd22);
    @(negedge clk);
    total++; if ({bus.req_ready, idle} !== 2'b00) begin bad++;
      $display("FAIL bb_cap req_ready/idle=%b want=00", {bus.req_ready, idle}); end
    @(posedge clk); #1;
    bus.dmem_b_valid = 1'b1; bus.dmem_b_resp = 2'd0;
    repeat (6) step();
    bus.dmem_b_valid = 1'b0;
    @(negedge clk);
    total++; if (bus.req_ready !== 1'b1) begin bad++;
      $display("FAIL bb_reopen req_ready=%b want=1", bus.req_ready); end
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      bus.dmem_r_valid = 1'b1; bus.dmem_r_data = 32'h1111_1111 * (i + 1); bus.dmem_r_resp = 2'd0;
      sb.push_back(mk(5'(21 + i), 32'h1111_1111 * (i + 1), 1'b1, 1'b0, 4'd0, 32'h600 + 4 * i));
      step();
    end
    bus.dmem_r_valid = 1'b0;
    wait_drain("bb");
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL bb_idle got=%b want=1", idle); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    bus.req_valid = 1'b0; bus.req_is_read = 1'b0; bus.req_is_memory = 1'b0;
    bus.req_size = 2'd0; bus.req_sign_extend = 1'b0; bus.req_misaligned = 1'b0;
    bus.req_addr = '0; bus.req_tag = '0;
    bus.dmem_r_valid = 1'b0; bus.dmem_r_data = '0; bus.dmem_r_resp = 2'd0;
    bus.dmem_b_valid = 1'b0; bus.dmem_b_resp = 2'd0;
    bus.out_ready = 1'b0;
    test_reset();
    test_signed_byte();
    test_posted_and_io_write();
    test_flush_drain();
    test_misaligned_store();
    test_err_backpressure();
    test_werr();
    test_back_to_back();
    total++; if (sb.size() != 0) begin bad++;
      $display("FAIL sb_leftover pending=%0d want=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
